// File: rtl/execute_stage.sv
// EX stage: operand forwarding from MEM/WB, 32-bit ALU, and the EX/MEM pipeline
// register with flush-to-bubble and a registered zero flag.
module execute_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] RD1_E,
   input  logic [31:0] RD2_E,
   input  logic [31:0] Extend_E,
   input  logic [2:0]  Alu_op_E,
   input  logic        Alu_src_E,
   input  logic        DM_Write_E,
   input  logic        Result_E,
   input  logic        RF_WE_E,
   input  logic [4:0]  RD_E,
   input  logic [4:0]  Rs1_E,
   input  logic [4:0]  Rs2_E,
   input  logic [31:0] Result_W,
   input  logic [4:0]  RDW,
   input  logic        RF_WE_W,
   input  logic        flush_E,
   output logic [31:0] Alu_result_M,
   output logic [31:0] WD_M,
   output logic [4:0]  RD_M,
   output logic        RF_WE_M,
   output logic        DM_WE_M,
   output logic        Result_M,
   output logic        Zero_M
);

   localparam int NUM_SRC = 2;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] wd;
      logic [4:0]  rd;
      logic        rf_we;
      logic        dm_we;
      logic        result_sel;
      logic        zero;
   } exmem_t;

   logic [NUM_SRC-1:0][4:0]  src_idx;
   logic [NUM_SRC-1:0][31:0] src_reg;
   logic [NUM_SRC-1:0]       mem_hit;
   logic [NUM_SRC-1:0]       wb_hit;
   logic [NUM_SRC-1:0][31:0] src_fwd;

   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_y;
   exmem_t      exmem_d;
   exmem_t      exmem_q;

   assign src_idx = {Rs2_E, Rs1_E};
   assign src_reg = {RD2_E, RD1_E};

   // MEM wins over WB; x0 is hardwired so it never forwards.
   for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
      assign mem_hit[g] = exmem_q.rf_we && (exmem_q.rd != 5'd0) && (exmem_q.rd == src_idx[g]);
      assign wb_hit[g]  = RF_WE_W && (RDW != 5'd0) && (RDW == src_idx[g]);
      assign src_fwd[g] = mem_hit[g] ? exmem_q.alu_result :
                          wb_hit[g]  ? Result_W           :
                                       src_reg[g];
   end

   assign alu_a = src_fwd[0];
   assign alu_b = Alu_src_E ? Extend_E : src_fwd[1];

   always_comb begin
      alu_y = 32'd0;
      case (Alu_op_E)
         ALU_ADD: alu_y = alu_a + alu_b;
         ALU_SUB: alu_y = alu_a - alu_b;
         ALU_AND: alu_y = alu_a & alu_b;
         ALU_OR:  alu_y = alu_a | alu_b;
         ALU_XOR: alu_y = alu_a ^ alu_b;
         ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLL: alu_y = alu_a << alu_b[4:0];
         ALU_SRL: alu_y = alu_a >> alu_b[4:0];
         default: alu_y = 32'd0;
      endcase
   end

   // Store data is the forwarded register value, never the immediate.
   always_comb begin
      exmem_d            = '0;
      exmem_d.alu_result = alu_y;
      exmem_d.wd         = src_fwd[1];
      exmem_d.rd         = RD_E;
      exmem_d.rf_we      = RF_WE_E;
      exmem_d.dm_we      = DM_Write_E;
      exmem_d.result_sel = Result_E;
      exmem_d.zero       = (alu_y == 32'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         exmem_q <= '0;
      else if (flush_E)
         exmem_q <= '0;
      else
         exmem_q <= exmem_d;
   end

   assign Alu_result_M = exmem_q.alu_result;
   assign WD_M         = exmem_q.wd;
   assign RD_M         = exmem_q.rd;
   assign RF_WE_M      = exmem_q.rf_we;
   assign DM_WE_M      = exmem_q.dm_we;
   assign Result_M     = exmem_q.result_sel;
   assign Zero_M       = exmem_q.zero;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, ALU sweep, forwarding, store, flush.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] RD1_E, RD2_E, Extend_E, Result_W;
   logic [2:0]  Alu_op_E;
   logic        Alu_src_E, DM_Write_E, Result_E, RF_WE_E, RF_WE_W, flush_E;
   logic [4:0]  RD_E, Rs1_E, Rs2_E, RDW;
   logic [31:0] Alu_result_M, WD_M;
   logic [4:0]  RD_M;
   logic        RF_WE_M, DM_WE_M, Result_M, Zero_M;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   execute_stage dut (
      .clk(clk), .rst(rst),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Extend_E(Extend_E),
      .Alu_op_E(Alu_op_E), .Alu_src_E(Alu_src_E), .DM_Write_E(DM_Write_E),
      .Result_E(Result_E), .RF_WE_E(RF_WE_E),
      .RD_E(RD_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
      .Result_W(Result_W), .RDW(RDW), .RF_WE_W(RF_WE_W), .flush_E(flush_E),
      .Alu_result_M(Alu_result_M), .WD_M(WD_M), .RD_M(RD_M),
      .RF_WE_M(RF_WE_M), .DM_WE_M(DM_WE_M), .Result_M(Result_M), .Zero_M(Zero_M)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      RD1_E = 0; RD2_E = 0; Extend_E = 0; Alu_op_E = 3'b000;
      Alu_src_E = 0; DM_Write_E = 0; Result_E = 0; RF_WE_E = 0;
      RD_E = 0; Rs1_E = 0; Rs2_E = 0;
      Result_W = 0; RDW = 0; RF_WE_W = 0; flush_E = 0;
   endtask

   task automatic test_reset();
      logic [75:0] got;
      rst = 0;
      RD1_E = 32'h11; RD2_E = 32'h22; Extend_E = 32'h33; Alu_op_E = 3'b011;
      DM_Write_E = 1; Result_E = 1; RF_WE_E = 1; RD_E = 5'd7;
      tick(); tick();
      got = {Alu_result_M, WD_M, RD_M, RF_WE_M, DM_WE_M, Result_M, Zero_M, 3'b000};
      n_checks++;
      if (got !== 76'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %h, required 0", got);
      end
      rst = 1;
      idle_inputs();
      RD1_E = 5; RD2_E = 7; RF_WE_E = 1; RD_E = 5'd3;
      tick();
      n_checks++;
      if (Alu_result_M !== 32'd12 || RD_M !== 5'd3 || RF_WE_M !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release_add: got res=%h rd=%0d we=%b, required 0000000c 3 1",
                  Alu_result_M, RD_M, RF_WE_M);
      end
   endtask

   task automatic test_alu_sweep();
      logic [31:0] exp_res [8] = '{32'hF0000013, 32'hF000000B, 32'h00000004, 32'hF000000F,
                                   32'hF000000B, 32'h00000001, 32'h000000F0, 32'h0F000000};
      idle_inputs();
      RD1_E = 32'hF000000F; RD2_E = 32'h00000004;
      for (int op = 0; op < 8; op++) begin
         Alu_op_E = op[2:0];
         tick();
         n_checks++;
         if (Alu_result_M !== exp_res[op] || Zero_M !== 1'b0) begin
            n_errors++;
            $display("FAIL alu_op%0d: got %h zero=%b, required %h zero=0",
                     op, Alu_result_M, Zero_M, exp_res[op]);
         end
      end
      RD1_E = 32'h1234; RD2_E = 32'h1234; Alu_op_E = 3'b001;
      tick();
      n_checks++;
      if (Alu_result_M !== 32'd0 || Zero_M !== 1'b1) begin
         n_errors++;
         $display("FAIL sub_zero: got %h zero=%b, required 0 zero=1", Alu_result_M, Zero_M);
      end
   endtask

   task automatic test_mem_forward();
      idle_inputs();
      RD1_E = 3; RD2_E = 4; RD_E = 5'd5; RF_WE_E = 1;
      tick();
      RD1_E = 0; RD2_E = 0; Rs1_E = 5'd5; Rs2_E = 5'd5; RD_E = 5'd6;
      tick();
      n_checks++;
      if (Alu_result_M !== 32'd14 || RD_M !== 5'd6) begin
         n_errors++;
         $display("FAIL mem_forward: got %h rd=%0d, required 0000000e rd=6", Alu_result_M, RD_M);
      end
   endtask

   task automatic test_priority_x0();
      idle_inputs();
      RD1_E = 20; RD_E = 5'd9; RF_WE_E = 1;
      tick();
      RD1_E = 0; Rs1_E = 5'd9; RD_E = 5'd10;
      RDW = 5'd9; RF_WE_W = 1; Result_W = 99;
      tick();
      n_checks++;
      if (Alu_result_M !== 32'd20) begin
         n_errors++;
         $display("FAIL mem_over_wb: got %0d, required 20", Alu_result_M);
      end
      // RD_M is now 10, so only WB matches x9
      RD_E = 5'd11;
      tick();
      n_checks++;
      if (Alu_result_M !== 32'd99) begin
         n_errors++;
         $display("FAIL wb_forward: got %0d, required 99", Alu_result_M);
      end
      idle_inputs();
      RD1_E = 20; RD_E = 5'd0; RF_WE_E = 1;
      tick();
      RD1_E = 55; Rs1_E = 5'd0; RD_E = 5'd12;
      RDW = 5'd0; RF_WE_W = 1; Result_W = 99;
      tick();
      n_checks++;
      if (Alu_result_M !== 32'd55) begin
         n_errors++;
         $display("FAIL x0_no_forward: got %0d, required 55", Alu_result_M);
      end
   endtask

   task automatic setup_store();
      idle_inputs();
      RD1_E = 100; Rs1_E = 5'd1; RD2_E = 0; Rs2_E = 5'd2;
      RDW = 5'd2; RF_WE_W = 1; Result_W = 32'hAB;
      Alu_src_E = 1; Extend_E = 8; DM_Write_E = 1;
   endtask

   task automatic test_store();
      idle_inputs();
      tick();
      setup_store();
      tick();
      n_checks++;
      if (WD_M !== 32'hAB || Alu_result_M !== 32'd108 || DM_WE_M !== 1'b1 || RF_WE_M !== 1'b0) begin
         n_errors++;
         $display("FAIL store: got wd=%h res=%0d dm=%b rf=%b, required ab 108 1 0",
                  WD_M, Alu_result_M, DM_WE_M, RF_WE_M);
      end
   endtask

   task automatic test_flush_reset();
      setup_store();
      flush_E = 1;
      tick();
      n_checks++;
      if (DM_WE_M !== 1'b0 || RF_WE_M !== 1'b0 || Alu_result_M !== 32'd0 || WD_M !== 32'd0) begin
         n_errors++;
         $display("FAIL flush_store: got dm=%b rf=%b res=%h wd=%h, required all 0",
                  DM_WE_M, RF_WE_M, Alu_result_M, WD_M);
      end
      idle_inputs();
      RD1_E = 1; RD2_E = 2; RD_E = 5'd4; RF_WE_E = 1; Result_E = 1;
      tick();
      n_checks++;
      if (Alu_result_M !== 32'd3 || Result_M !== 1'b1 || RD_M !== 5'd4) begin
         n_errors++;
         $display("FAIL post_flush_capture: got res=%0d sel=%b rd=%0d, required 3 1 4",
                  Alu_result_M, Result_M, RD_M);
      end
      flush_E = 1; rst = 0;
      tick();
      n_checks++;
      if (Alu_result_M !== 0 || RD_M !== 0 || RF_WE_M !== 0 || Result_M !== 0 || Zero_M !== 0) begin
         n_errors++;
         $display("FAIL flush_reset: got res=%h rd=%0d rf=%b sel=%b z=%b, required all 0",
                  Alu_result_M, RD_M, RF_WE_M, Result_M, Zero_M);
      end
      rst = 1; flush_E = 0;
   endtask

   initial begin
      idle_inputs();
      rst = 0;
      test_reset();
      test_alu_sweep();
      test_mem_forward();
      test_priority_x0();
      test_store();
      test_flush_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage pipeline. It consumes the registered decode-stage outputs (operands, immediate, ALU opcode and control bits) and resolves RAW hazards by forwarding from the MEM and WB stages. It computes the ALU result and captures result, store data and control into the EX/MEM pipeline register for the memory stage. The block adds one cycle of latency, flush-to-bubble support and a registered zero flag.

## Interface
Parameters:
- none (datapath fixed at 32 bits, register index at 5 bits)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-low (rst=0 clears state at the next clk rising edge)
- RD1_E  in  32  register operand A from decode
- RD2_E  in  32  register operand B from decode
- Extend_E  in  32  sign-extended immediate
- Alu_op_E  in  3  ALU control
- Alu_src_E  in  1  1 = B operand is Extend_E, 0 = forwarded RD2
- DM_Write_E  in  1  store enable
- Result_E  in  1  result select (0 = ALU, 1 = memory)
- RF_WE_E  in  1  register-file write enable
- RD_E, Rs1_E, Rs2_E  in  5 each  destination and source register indices
- Result_W  in  32  writeback-stage result
- RDW  in  5  writeback destination index
- RF_WE_W  in  1  writeback write enable
- flush_E  in  1  active-high; turns the captured instruction into a bubble
- Alu_result_M  out  32  registered ALU result
- WD_M  out  32  registered store data (forwarded B, before immediate mux)
- RD_M  out  5  registered destination index
- RF_WE_M, DM_WE_M, Result_M, Zero_M  out  1 each  registered control and zero flag

## Operation
- Forward select for A (same rules for B with Rs2_E and RD2_E):
  - MEM hit: RF_WE_M=1, RD_M≠0 and RD_M=Rs1_E selects Alu_result_M.
  - Otherwise WB hit: RF_WE_W=1, RDW≠0 and RDW=Rs1_E selects Result_W.
  - Otherwise RD1_E.
  - MEM has priority when both hit. Index 0 is never forwarded.
- Operand B = Alu_src_E ? Extend_E : forwarded B. WD_M is always captured from forwarded B.
- ALU encoding:
  - 000 ADD; 001 SUB; 010 AND; 011 OR; 100 XOR.
  - 101 SLT: signed compare, result 32'd1 or 32'd0.
  - 110 SLL and 111 SRL: logical shift by B[4:0].
- Add and subtract wrap modulo 2^32. No overflow flag.
- Zero = (ALU result == 0).
- Load-use hazards are not detected here. The upstream hazard unit stalls or flushes. A MEM hit always forwards Alu_result_M.

## Timing
- Combinational path: forwarding, then ALU, then EX/MEM register. Latency is 1 cycle: inputs valid in cycle n appear on the *_M outputs after edge n+1.
- Priority at each rising edge: rst=0 first, then flush_E=1, then normal capture.
- Reset (rst=0): all outputs go to 0 at the next edge, including a reset asserted mid-stream. The first instruction after release is captured at the first edge with rst=1.
- Flush (flush_E=1): RF_WE_M, DM_WE_M and Result_M are captured as 0; Alu_result_M, WD_M, RD_M and Zero_M as 0.
- The WB forward path is purely combinational from Result_W, RDW and RF_WE_W in the same cycle. No internal write-through is assumed from the register file.
- Back-to-back dependent instructions need no stall unless the producer is a load.

## Test plan
- Reset sequencing: hold rst=0 for 2 edges with nonzero inputs -> all outputs 0. Release -> the next edge captures ADD of 5 and 7, giving Alu_result_M=12.
- ALU sweep with A=0xF000000F, B=0x00000004, Alu_src_E=0. Required results:
  - ADD 0xF0000013; SUB 0xF000000B; AND 4; OR 0xF000000F; XOR 0xF000000B.
  - SLT 1; SLL 0x000000F0; SRL 0x0F000000.
  - SUB of equal operands gives Zero_M=1.
- MEM forwarding: `add x5=3+4` then `add x6=x5+x5` with stale RD1_E=RD2_E=0 -> second Alu_result_M=14.
- Priority and x0:
  - RD_M=RDW=Rs1_E=9, Alu_result_M=20, Result_W=99 -> A=20.
  - With RD=0 on the producer -> no forward; RD1_E is used.
- Store: Alu_src_E=1, Extend_E=8, Rs2_E hits WB with Result_W=0xAB -> WD_M=0xAB, Alu_result_M=A+8, DM_WE_M=1.
- Flush and reset collision:
  - flush_E=1 with a valid store -> DM_WE_M=0, RF_WE_M=0.
  - flush_E=1 and rst=0 together -> reset values.
